led_bank_arbiter: RTL and testbench
===================================

// Module: led_bank_arbiter
// PURPOSE
//   Shares the 4-bit on-board LED bank between NREQ pattern generators, e.g. the
//   scanner, a status display and a debug source.
//   - Round-robin arbitration with a tick-based minimum hold time.
//   - A built-in prescaler provides the slow time base.
//   - Drives the active-low LED pins directly; sits between the generators and the top-level led port.
// PARAMETERS
//   NREQ        4    number of requesters (2..8)
//   LED_W       4    LED bank width
//   DIV_W       21   prescaler width; tick period = 2**DIV_W clk cycles
//   HOLD_TICKS  8    ticks the owner keeps the bank before yielding to a pending request (>=1)
// PORTS
//   clk      in   1            system clock (internal oscillator domain)
//   rst      in   1            asynchronous reset, active-high
//   req      in   NREQ         request per requester; level, held while ownership is wanted
//   pattern  in   NREQ*LED_W   active-high LED pattern, requester i at [i*LED_W +: LED_W]
//   gnt      out  NREQ         one-hot grant, registered
//   led      out  LED_W        LED pins, active-low (1 = off)
//   busy     out  1            bank owned or releasing (state != IDLE)
//   tick     out  1            1-cycle prescaler pulse
// BEHAVIOUR
//   Reset: the asynchronous assert forces the following values.
//     - Outputs: gnt=0, led=all-ones, busy=0, tick=0.
//     - Internal: state=IDLE, prescaler=0, hold_cnt=0, rr_ptr=NREQ-1.
//     - Reset mid-grant drops ownership immediately. Release is synchronous.
//   Prescaler: a DIV_W-bit counter increments every cycle and wraps.
//     - tick is registered: it is high for the cycle after the counter equals 2**DIV_W-1.
//   The FSM is registered and has three states: IDLE, GRANT and RELEASE.
//   IDLE:
//     - gnt=0 and led=all-ones.
//     - If req!=0, select the first set bit searching from rr_ptr+1 upward, wrapping modulo NREQ.
//     - On that edge: owner<=sel, gnt<=onehot(sel), hold_cnt<=0, state<=GRANT.
//     - Latency: req rising in cycle N gives gnt high in cycle N+1.
//   GRANT:
//     - led <= ~pattern[owner] every cycle, so pattern changes appear one cycle later.
//     - hold_cnt increments on each tick and saturates at HOLD_TICKS.
//     - Leave for RELEASE when req[owner]==0, at any hold_cnt value.
//     - Also leave when hold_cnt==HOLD_TICKS and (req & ~onehot(owner))!=0.
//     - A lone owner that keeps its req asserted retains the bank indefinitely.
//   RELEASE (exactly 1 cycle):
//     - gnt=0, led=all-ones, rr_ptr<=owner, then state<=IDLE.
//     - Guarantees at least 2 cycles with no grant between owners, so no two grants are ever high together.
//   Simultaneous events:
//     - Requests arriving during GRANT or RELEASE are only sampled in IDLE.
//     - A hold expiry on the same cycle as the owner dropping req gives a single release.
//     - A tick on the grant cycle is not counted, because hold_cnt is cleared on that edge.
//   Invariants:
//     - gnt is zero or one-hot.
//     - gnt!=0 implies state==GRANT.
//     - led==all-ones whenever gnt==0, apart from the cycle after the drop in which led still shows the last pattern.
//     - busy=1 in GRANT and RELEASE.
// TESTING (DIV_W=2 so tick every 4 cycles, HOLD_TICKS=2, NREQ=4)
//   1. Reset with req=0 -> gnt=0, led=4'hF, busy=0; tick first pulses 4 cycles after rst falls.
//   2. Single request: req=4'b0100, pattern2=4'b1010 -> gnt=4'b0100 one cycle later, led=4'b0101
//      one cycle after that; held while req2 stays high, even with hold expired.
//   3. Contention: req=4'b0011 from IDLE with rr_ptr=3 -> gnt0 first. After 2 ticks gnt drops
//      for 2 cycles, then gnt=4'b0010.
//   4. Round-robin: req=4'b1111 held high -> grant order 0,1,2,3,0, each held exactly 2 ticks
//      plus the release/IDLE gap.
//   5. Early drop: the owner clears req at hold_cnt=0 -> RELEASE next cycle and led=4'hF after it.
//      A pending requester is granted in the following cycle.
//   6. rst pulsed mid-GRANT -> gnt, led and busy go to reset values with no clock edge.
//      After release, rr_ptr=3 so req0 wins first.

Source files
------------

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the shared active-low LED bank, with a prescaled tick
// that sets how long an owner keeps the bank once another requester is waiting.
module led_bank_arbiter #(
    parameter int NREQ       = 4,
    parameter int LED_W      = 4,
    parameter int DIV_W      = 21,
    parameter int HOLD_TICKS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LED_W-1:0] pattern,
    output logic [NREQ-1:0]       gnt,
    output logic [LED_W-1:0]      led,
    output logic                  busy,
    output logic                  tick,
    output logic [1:0]            fsm_state   // 0 = IDLE, 1 = GRANT, 2 = RELEASE
);
    // Handshake: req is a level held while ownership is wanted; gnt is the
    // registered answer and stays high until the owner drops req or must yield.

    localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  owner;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  sel;
    logic              found;
    logic [HOLD_W-1:0] hold_cnt;
    logic [DIV_W-1:0]  prescaler;
    logic [NREQ-1:0]   owner_oh;
    logic              hold_done;
    logic              yield;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            tick      <= 1'b0;
        end else begin
            prescaler <= prescaler + DIV_W'(1);
            tick      <= &prescaler;
        end
    end

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[PTR_W'((int'(rr_ptr) + k) % NREQ)]) begin
                sel   = PTR_W'((int'(rr_ptr) + k) % NREQ);
                found = 1'b1;
            end
        end
    end

    assign owner_oh  = NREQ'(1) << owner;
    assign hold_done = (hold_cnt == HOLD_W'(HOLD_TICKS));
    assign yield     = !req[owner] || (hold_done && ((req & ~owner_oh) != '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            led      <= '1;
            owner    <= '0;
            rr_ptr   <= PTR_W'(NREQ - 1);
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    gnt <= '0;
                    led <= '1;
                    if (found) begin
                        owner    <= sel;
                        gnt      <= NREQ'(1) << sel;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    led <= ~pattern[int'(owner)*LED_W +: LED_W];
                    if (tick && !hold_done)
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    if (yield) begin
                        gnt   <= '0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    gnt    <= '0;
                    led    <= '1;
                    rr_ptr <= owner;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Randomised and directed bench for led_bank_arbiter against a cycle-level
// reference built from ownership/tick-count rules.
module tb_led_bank_arbiter;
    localparam int NREQ   = 4;
    localparam int LED_W  = 4;
    localparam int DIV_W  = 2;
    localparam int HOLD   = 2;
    localparam int PERIOD = 1 << DIV_W;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*LED_W-1:0] pattern;
    logic [NREQ-1:0]       gnt;
    logic [LED_W-1:0]      led;
    logic                  busy;
    logic                  tick;
    logic [1:0]            fsm_state;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: who owns the bank, ticks seen since grant, last owner
    int              m_owner;
    int              m_last;
    int              m_ticks;
    int              m_edges;
    bit              m_rel;
    logic            m_tick;
    logic [NREQ-1:0] m_gnt;
    logic [LED_W-1:0] m_led;

    led_bank_arbiter #(
        .NREQ(NREQ), .LED_W(LED_W), .DIV_W(DIV_W), .HOLD_TICKS(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .pattern(pattern),
        .gnt(gnt), .led(led), .busy(busy), .tick(tick), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_last  = NREQ - 1;
        m_ticks = 0;
        m_edges = 0;
        m_rel   = 1'b0;
        m_tick  = 1'b0;
        m_gnt   = '0;
        m_led   = '1;
    endtask

    task automatic model_step();
        logic [NREQ-1:0] oh;
        bit done;
        if (m_rel) begin
            m_rel = 1'b0;
            m_gnt = '0;
            m_led = '1;
        end else if (m_owner < 0) begin
            m_gnt = '0;
            m_led = '1;
            done  = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                if (!done && req[(m_last + k) % NREQ]) begin
                    m_owner = (m_last + k) % NREQ;
                    done    = 1'b1;
                end
            end
            if (done) begin
                m_ticks = 0;
                m_gnt   = '0;
                m_gnt[m_owner] = 1'b1;
            end
        end else begin
            m_led = ~pattern[m_owner*LED_W +: LED_W];
            oh = '0;
            oh[m_owner] = 1'b1;
            if (!req[m_owner] || (m_ticks >= HOLD && (req & ~oh) != '0)) begin
                m_last  = m_owner;
                m_owner = -1;
                m_rel   = 1'b1;
                m_gnt   = '0;
            end else if (m_tick) begin
                m_ticks++;
            end
        end
        m_edges++;
        m_tick = (m_edges % PERIOD == 0);
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic exp_t;
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        pattern = $urandom;
        model_reset();
        #2;
        n_checks++; if (gnt !== '0) $display("FAIL reset_gnt got=%b exp=0000", gnt); else n_pass++;
        n_checks++; if (led !== 4'hF) $display("FAIL reset_led got=%h exp=f", led); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (tick !== 1'b0) $display("FAIL reset_tick got=%b exp=0", tick); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick_cycle();
            exp_t = (i == 4);
            n_checks++;
            if (tick !== exp_t) $display("FAIL reset_tick_first cyc=%0d got=%b exp=%b", i, tick, exp_t);
            else n_pass++;
            n_checks++;
            if (gnt !== '0 || busy !== 1'b0) $display("FAIL reset_idle cyc=%0d gnt=%b busy=%b exp=0000/0", i, gnt, busy);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        do_reset();
        pattern = $urandom;
        pattern[11:8] = 4'b1010;
        req = 4'b0100;
        tick_cycle();
        n_checks++; if (gnt !== 4'b0100) $display("FAIL single_latency got=%b exp=0100", gnt); else n_pass++;
        n_checks++; if (led !== 4'hF) $display("FAIL single_led_first got=%b exp=1111", led); else n_pass++;
        tick_cycle();
        n_checks++; if (led !== 4'b0101) $display("FAIL single_led got=%b exp=0101", led); else n_pass++;
        for (int i = 0; i < 30; i++) begin
            tick_cycle();
            n_checks++;
            if (gnt !== 4'b0100 || gnt !== m_gnt) $display("FAIL single_hold cyc=%0d got=%b exp=0100", i, gnt);
            else n_pass++;
            n_checks++;
            if (led !== m_led) $display("FAIL single_led_hold cyc=%0d got=%b exp=%b", i, led, m_led);
            else n_pass++;
        end
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] first_g, second_g;
        int gap;
        do_reset();
        pattern = $urandom;
        req = 4'b0011;
        first_g = '0;
        second_g = '0;
        gap = 0;
        for (int i = 0; i < 40; i++) begin
            tick_cycle();
            n_checks++;
            if (gnt !== m_gnt || led !== m_led || busy !== (m_owner >= 0 || m_rel))
                $display("FAIL contention_model cyc=%0d gnt=%b led=%b busy=%b exp=%b/%b", i, gnt, led, busy, m_gnt, m_led);
            else n_pass++;
            if (gnt != '0 && first_g == '0) first_g = gnt;
            else if (gnt != '0 && gnt != first_g && second_g == '0) second_g = gnt;
            else if (gnt == '0 && first_g != '0 && second_g == '0) gap++;
        end
        n_checks++; if (first_g !== 4'b0001) $display("FAIL contention_first got=%b exp=0001", first_g); else n_pass++;
        n_checks++; if (second_g !== 4'b0010) $display("FAIL contention_second got=%b exp=0010", second_g); else n_pass++;
        n_checks++; if (gap !== 2) $display("FAIL contention_gap got=%0d exp=2", gap); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] order_q[$];
        logic [NREQ-1:0] prev, exp_g;
        do_reset();
        pattern = $urandom;
        req = 4'b1111;
        prev = '0;
        for (int i = 0; i < 100; i++) begin
            tick_cycle();
            n_checks++;
            if (gnt !== m_gnt || led !== m_led)
                $display("FAIL rr_model cyc=%0d gnt=%b led=%b exp=%b/%b", i, gnt, led, m_gnt, m_led);
            else n_pass++;
            if (prev == '0 && gnt != '0) order_q.push_back(gnt);
            prev = gnt;
        end
        n_checks++;
        if (order_q.size() < 5) $display("FAIL rr_count got=%0d exp>=5", order_q.size());
        else n_pass++;
        for (int k = 0; k < 5 && k < order_q.size(); k++) begin
            exp_g = '0;
            exp_g[k % NREQ] = 1'b1;
            n_checks++;
            if (order_q[k] !== exp_g) $display("FAIL rr_order idx=%0d got=%b exp=%b", k, order_q[k], exp_g);
            else n_pass++;
        end
    endtask

    task automatic test_early_drop();
        logic [LED_W-1:0] p0;
        do_reset();
        pattern = $urandom;
        p0 = pattern[3:0];
        req = 4'b0001;
        for (int w = 0; w < 10 && gnt == '0; w++) tick_cycle();
        n_checks++; if (gnt !== 4'b0001) $display("FAIL drop_grant got=%b exp=0001", gnt); else n_pass++;
        req = 4'b0100;
        tick_cycle();
        n_checks++;
        if (gnt !== '0 || busy !== 1'b1 || led !== ~p0)
            $display("FAIL drop_release gnt=%b busy=%b led=%b exp=0000/1/%b", gnt, busy, led, ~p0);
        else n_pass++;
        tick_cycle();
        n_checks++;
        if (gnt !== '0 || busy !== 1'b0 || led !== 4'hF)
            $display("FAIL drop_idle gnt=%b busy=%b led=%b exp=0000/0/1111", gnt, busy, led);
        else n_pass++;
        tick_cycle();
        n_checks++; if (gnt !== 4'b0100) $display("FAIL drop_next got=%b exp=0100", gnt); else n_pass++;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        pattern = $urandom;
        req = 4'b0100;
        for (int w = 0; w < 10 && gnt == '0; w++) tick_cycle();
        repeat (3) tick_cycle();
        n_checks++; if (gnt !== 4'b0100) $display("FAIL midrst_pre got=%b exp=0100", gnt); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (gnt !== '0 || led !== 4'hF || busy !== 1'b0 || tick !== 1'b0)
            $display("FAIL midrst_async gnt=%b led=%b busy=%b tick=%b exp=0000/1111/0/0", gnt, led, busy, tick);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        for (int w = 0; w < 10 && gnt == '0; w++) tick_cycle();
        n_checks++; if (gnt !== 4'b0001) $display("FAIL midrst_first got=%b exp=0001", gnt); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        pattern = $urandom;
        req = NREQ'($urandom_range(0, 15));
        for (int i = 0; i < 400; i++) begin
            tick_cycle();
            n_checks++;
            if (gnt !== m_gnt) $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", i, gnt, m_gnt); else n_pass++;
            n_checks++;
            if (led !== m_led) $display("FAIL rand_led cyc=%0d got=%b exp=%b", i, led, m_led); else n_pass++;
            n_checks++;
            if (busy !== (m_owner >= 0 || m_rel) || tick !== m_tick)
                $display("FAIL rand_busy_tick cyc=%0d got=%b/%b exp=%b/%b", i, busy, tick, (m_owner >= 0 || m_rel), m_tick);
            else n_pass++;
            n_checks++;
            if (!$onehot0(gnt) || (gnt != '0 && fsm_state !== 2'd1))
                $display("FAIL rand_invariant cyc=%0d gnt=%b state=%0d exp=onehot0/1", i, gnt, fsm_state);
            else n_pass++;
            if ($urandom_range(0, 5) == 0) req = NREQ'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) pattern = $urandom;
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        pattern = '0;
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        test_early_drop();
        test_reset_mid_grant();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
